// File: rtl/pin_ctrl_gen.sv
// pin_ctrl_gen
//   Drives NUM_PINS output pins with a square wave at a programmed frequency.
//   The programmed frequency (Hz) is converted to a half-period cycle count by
//   an iterative restoring divider. Frequency and pin mask are double-buffered
//   and only take effect at a period boundary (high->low transition) while
//   running, so the outputs never show a shortened phase. An optional burst
//   mode emits a fixed number of periods and then stops.
//
// Ports
//   sys_clk      in   single clock, rising edge
//   sys_rst      in   synchronous, active-high reset
//   sw_en        in   level: 1 = run, 0 = stop
//   set_fre_en   in   rising edge starts a frequency load from set_fre
//   set_fre      in   requested frequency in Hz (CNT_W bits)
//   set_pins_en  in   rising edge loads set_pins into the pending mask
//   set_pins     in   pin enable mask, 1 = pin toggles
//   burst_mode   in   0 = continuous, 1 = burst (sampled when starting)
//   burst_len    in   periods per burst, 0 behaves as 1 (sampled when starting)
//   pins_out     out  registered pin outputs
//   busy         out  1 while running
//   done         out  one-cycle pulse at the end of a burst
//   cfg_err      out  sticky flag for an unusable set_fre
module pin_ctrl_gen #(
    parameter int NUM_PINS    = 20,
    parameter int CNT_W       = 32,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEFAULT_FRE = 1000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                sw_en,
    input  logic                set_fre_en,
    input  logic [CNT_W-1:0]    set_fre,
    input  logic                set_pins_en,
    input  logic [NUM_PINS-1:0] set_pins,
    input  logic                burst_mode,
    input  logic [15:0]         burst_len,
    output logic [NUM_PINS-1:0] pins_out,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    localparam logic [CNT_W-1:0] HALF_CLK = CNT_W'(CLK_FREQ_HZ / 2);
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(CLK_FREQ_HZ / (2 * DEFAULT_FRE));
    localparam int               DC_W     = $clog2(CNT_W + 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    // enable edge detection
    logic fre_en_q;
    logic pins_en_q;
    logic fre_rise;
    logic pins_rise;
    logic fre_illegal;

    // divider
    logic             div_busy;
    logic [DC_W-1:0]  div_cnt;
    logic [CNT_W-1:0] div_rem;
    logic [CNT_W-1:0] div_quo;
    logic [CNT_W-1:0] div_dvsr;
    logic [CNT_W:0]   div_shift;
    logic             div_ge;
    logic [CNT_W-1:0] rem_nxt;
    logic [CNT_W-1:0] quo_nxt;

    // pending / active configuration
    logic [CNT_W-1:0]    pend_half;
    logic                pend_half_vld;
    logic [NUM_PINS-1:0] pend_mask;
    logic                pend_mask_vld;
    logic [CNT_W-1:0]    active_half;
    logic [NUM_PINS-1:0] active_mask;
    logic [NUM_PINS-1:0] mask_nxt;

    // run-time counters
    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic [CNT_W-1:0] half_m1;
    logic             phase_end;
    logic             boundary_fall;
    logic             apply_half;
    logic             apply_mask;
    logic             burst_on;
    logic [15:0]      burst_tgt;
    logic [15:0]      burst_cnt;
    logic             rearm_wait;

    assign fre_rise  = set_fre_en & ~fre_en_q;
    assign pins_rise = set_pins_en & ~pins_en_q;

    // q = floor(HALF_CLK / set_fre) is zero exactly when set_fre > HALF_CLK,
    // so both illegal cases are screened before the divider is started.
    assign fre_illegal = (set_fre == '0) || (set_fre > HALF_CLK);

    assign half_m1       = active_half - ONE;
    assign phase_end     = (cnt == half_m1);
    assign boundary_fall = (state == RUN) && phase && phase_end;
    assign apply_half    = pend_half_vld && ((state == IDLE) || boundary_fall);
    assign apply_mask    = pend_mask_vld && ((state == IDLE) || boundary_fall);

    always_comb begin
        div_shift = {div_rem, div_quo[CNT_W-1]};
        div_ge    = (div_shift >= {1'b0, div_dvsr});
        // When div_ge holds the true difference is below div_dvsr, so the
        // low CNT_W bits of the subtraction are exact.
        rem_nxt   = div_ge ? (div_shift[CNT_W-1:0] - div_dvsr) : div_shift[CNT_W-1:0];
        quo_nxt   = {div_quo[CNT_W-2:0], div_ge};
        mask_nxt  = apply_mask ? pend_mask : active_mask;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fre_en_q  <= 1'b0;
            pins_en_q <= 1'b0;
        end else begin
            fre_en_q  <= set_fre_en;
            pins_en_q <= set_pins_en;
        end
    end

    // Frequency path: screening, restoring divide, pending half-period.
    // Start edge, CNT_W iteration cycles, then one cycle to publish.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_busy      <= 1'b0;
            div_cnt       <= '0;
            div_rem       <= '0;
            div_quo       <= '0;
            div_dvsr      <= '0;
            pend_half     <= RST_HALF;
            pend_half_vld <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            if (apply_half) begin
                pend_half_vld <= 1'b0;
            end
            if (div_busy) begin
                if (div_cnt != '0) begin
                    div_rem <= rem_nxt;
                    div_quo <= quo_nxt;
                    div_cnt <= div_cnt - DC_W'(1);
                end else begin
                    pend_half     <= div_quo;
                    pend_half_vld <= 1'b1;
                    div_busy      <= 1'b0;
                end
            end else if (fre_rise) begin
                if (fre_illegal) begin
                    cfg_err <= 1'b1;
                end else begin
                    cfg_err  <= 1'b0;
                    div_busy <= 1'b1;
                    div_cnt  <= DC_W'(CNT_W);
                    div_rem  <= '0;
                    div_quo  <= HALF_CLK;
                    div_dvsr <= set_fre;
                end
            end
        end
    end

    // Pending mask; a new load in the same cycle as an apply wins.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pend_mask     <= '0;
            pend_mask_vld <= 1'b0;
        end else begin
            if (apply_mask) begin
                pend_mask_vld <= 1'b0;
            end
            if (pins_rise) begin
                pend_mask     <= set_pins;
                pend_mask_vld <= 1'b1;
            end
        end
    end

    // state | meaning
    // IDLE  | pins low, waiting for sw_en (and for sw_en to drop after a burst)
    // RUN   | square wave: phase 1 drives active_mask, phase 0 drives zero
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            phase       <= 1'b0;
            active_half <= RST_HALF;
            active_mask <= '1;
            pins_out    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            burst_on    <= 1'b0;
            burst_tgt   <= 16'd1;
            burst_cnt   <= '0;
            rearm_wait  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (apply_half) begin
                active_half <= pend_half;
            end
            if (apply_mask) begin
                active_mask <= pend_mask;
            end
            case (state)
                IDLE: begin
                    pins_out <= '0;
                    busy     <= 1'b0;
                    if (!sw_en) begin
                        rearm_wait <= 1'b0;
                    end
                    if (sw_en && !rearm_wait) begin
                        state     <= RUN;
                        cnt       <= '0;
                        phase     <= 1'b1;
                        pins_out  <= mask_nxt;
                        busy      <= 1'b1;
                        burst_on  <= burst_mode;
                        burst_tgt <= (burst_len == 16'd0) ? 16'd1 : burst_len;
                        burst_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!sw_en) begin
                        state    <= IDLE;
                        pins_out <= '0;
                        busy     <= 1'b0;
                    end else if (phase_end) begin
                        cnt <= '0;
                        if (phase) begin
                            phase    <= 1'b0;
                            pins_out <= '0;
                            if (burst_on) begin
                                burst_cnt <= burst_cnt + 16'd1;
                            end
                        end else if (burst_on && (burst_cnt == burst_tgt)) begin
                            // last low phase of the burst just completed
                            state      <= IDLE;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            pins_out   <= '0;
                            rearm_wait <= 1'b1;
                        end else begin
                            phase    <= 1'b1;
                            pins_out <= active_mask;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pin_ctrl_gen.sv
// tb_pin_ctrl_gen
//   Directed bench for pin_ctrl_gen with NUM_PINS=8, CNT_W=16,
//   CLK_FREQ_HZ=1000, DEFAULT_FRE=100 (reset half-period of 5 cycles).
//   Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_pin_ctrl_gen;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        sw_en;
    logic        set_fre_en;
    logic [15:0] set_fre;
    logic        set_pins_en;
    logic [7:0]  set_pins;
    logic        burst_mode;
    logic [15:0] burst_len;
    logic [7:0]  pins_out;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] fre;
        logic        err;
        int          half;
    } fre_vec_t;

    fre_vec_t vecs [7];

    pin_ctrl_gen #(
        .NUM_PINS   (8),
        .CNT_W      (16),
        .CLK_FREQ_HZ(1000),
        .DEFAULT_FRE(100)
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .sw_en      (sw_en),
        .set_fre_en (set_fre_en),
        .set_fre    (set_fre),
        .set_pins_en(set_pins_en),
        .set_pins   (set_pins),
        .burst_mode (burst_mode),
        .burst_len  (burst_len),
        .pins_out   (pins_out),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Sync to the next low->high transition, then measure one full period.
    task automatic meas(output int hi, output int lo, output logic [7:0] hv);
        int guard;
        guard = 0;
        hi = 0;
        lo = 0;
        while (pins_out != 8'h00 && guard < 4000) begin step(1); guard++; end
        while (pins_out == 8'h00 && guard < 4000) begin step(1); guard++; end
        hv = pins_out;
        while (pins_out != 8'h00 && guard < 4000) begin hi++; step(1); guard++; end
        while (pins_out == 8'h00 && guard < 4000) begin lo++; step(1); guard++; end
        if (guard >= 4000) begin
            total++;
            bad++;
            $display("FAIL meas_timeout: got no full period within 4000 cycles");
        end
    endtask

    task automatic load_fre(input logic [15:0] f);
        set_fre    = f;
        set_fre_en = 1'b1;
        step(1);
        set_fre_en = 1'b0;
        step(20);
    endtask

    task automatic run_burst(input logic [15:0] len, input int periods, input int half, input string tag);
        int         rises;
        int         highs;
        int         busys;
        int         dones;
        int         done_dirty;
        logic [7:0] prev;
        rises = 0; highs = 0; busys = 0; dones = 0; done_dirty = 0; prev = 8'h00;
        sw_en = 1'b0;
        step(2);
        burst_mode = 1'b1;
        burst_len  = len;
        sw_en      = 1'b1;
        for (int i = 0; i < 2 * half * periods + 60; i++) begin
            step(1);
            if (pins_out != 8'h00) highs++;
            if (prev == 8'h00 && pins_out != 8'h00) rises++;
            if (busy) busys++;
            if (done) begin
                dones++;
                if (pins_out != 8'h00 || busy) done_dirty++;
            end
            prev = pins_out;
        end
        chk({tag, "_periods"}, rises, periods);
        chk({tag, "_high_cycles"}, highs, periods * half);
        chk({tag, "_busy_cycles"}, busys, 2 * half * periods);
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_outputs_at_done"}, done_dirty, 0);
        chk({tag, "_idle_pins"}, pins_out, 8'h00);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int         hi;
        int         lo;
        logic [7:0] hv;

        vecs[0] = '{fre: 16'd0,   err: 1'b1, half: 10};
        vecs[1] = '{fre: 16'd600, err: 1'b1, half: 10};
        vecs[2] = '{fre: 16'd250, err: 1'b0, half: 2};
        vecs[3] = '{fre: 16'd500, err: 1'b0, half: 1};
        vecs[4] = '{fre: 16'd501, err: 1'b1, half: 1};
        vecs[5] = '{fre: 16'd7,   err: 1'b0, half: 71};
        vecs[6] = '{fre: 16'd100, err: 1'b0, half: 5};

        sys_rst     = 1'b1;
        sw_en       = 1'b0;
        set_fre_en  = 1'b0;
        set_fre     = '0;
        set_pins_en = 1'b0;
        set_pins    = '0;
        burst_mode  = 1'b0;
        burst_len   = '0;
        step(2);
        chk("rst_pins", pins_out, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);

        // continuous run at the reset frequency
        sys_rst = 1'b0;
        sw_en   = 1'b1;
        step(1);
        chk("start_pins", pins_out, 8'hFF);
        chk("start_busy", busy, 1);
        meas(hi, lo, hv);
        chk("t1_high", hi, 5);
        chk("t1_low", lo, 5);
        chk("t1_level", hv, 8'hFF);

        // new frequency becomes pending exactly on a boundary edge, so it
        // must wait for the following boundary
        step(7);
        set_fre    = 16'd50;
        set_fre_en = 1'b1;
        step(1);
        set_fre_en = 1'b0;
        meas(hi, lo, hv);
        chk("t2_pre_high", hi, 5);
        chk("t2_pre_low", lo, 5);
        meas(hi, lo, hv);
        chk("t2_switch_high", hi, 5);
        chk("t2_switch_low", lo, 10);
        meas(hi, lo, hv);
        chk("t2_new_high", hi, 10);
        chk("t2_new_low", lo, 10);

        // mask load mid-high-phase
        step(3);
        set_pins    = 8'hA5;
        set_pins_en = 1'b1;
        step(1);
        set_pins_en = 1'b0;
        chk("t3_mid_high_level", pins_out, 8'hFF);
        meas(hi, lo, hv);
        chk("t3_new_level", hv, 8'hA5);
        chk("t3_high", hi, 10);
        chk("t3_low", lo, 10);

        // abort by dropping sw_en mid-run
        sw_en = 1'b0;
        step(2);
        sw_en = 1'b1;
        step(3);
        chk("abort_running", pins_out, 8'hA5);
        sw_en = 1'b0;
        step(1);
        chk("abort_pins", pins_out, 8'h00);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);

        // bursts, including the zero-length case
        run_burst(16'd3, 3, 10, "burst3");
        run_burst(16'd0, 1, 10, "burst0");
        burst_mode = 1'b0;

        // frequency table applied while idle
        for (int i = 0; i < 7; i++) begin
            sw_en = 1'b0;
            step(2);
            load_fre(vecs[i].fre);
            chk($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].err);
            sw_en = 1'b1;
            meas(hi, lo, hv);
            chk($sformatf("vec%0d_high", i), hi, vecs[i].half);
            chk($sformatf("vec%0d_low", i), lo, vecs[i].half);
        end

        // reset mid-burst and mid-divide
        sw_en = 1'b0;
        step(2);
        load_fre(16'd50);
        load_fre(16'd0);
        chk("t6_err_before_rst", cfg_err, 1);
        burst_mode = 1'b1;
        burst_len  = 16'd3;
        sw_en      = 1'b1;
        step(5);
        set_fre    = 16'd250;
        set_fre_en = 1'b1;
        step(1);
        set_fre_en = 1'b0;
        step(4);
        sys_rst = 1'b1;
        step(1);
        chk("t6_rst_pins", pins_out, 8'h00);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_cfg_err", cfg_err, 0);
        burst_mode = 1'b0;
        sys_rst    = 1'b0;
        meas(hi, lo, hv);
        chk("t6_high_a", hi, 5);
        chk("t6_low_a", lo, 5);
        chk("t6_level", hv, 8'hFF);
        meas(hi, lo, hv);
        chk("t6_high_b", hi, 5);
        chk("t6_low_b", lo, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
